// File: rtl/mmio_io_ctrl_pkg.sv
// Shared constants for the MMIO responder: register addresses, CTRL bit
// positions, the unmapped read value and a small address decoder.
package mmio_io_ctrl_pkg;

  localparam logic [11:0] IO_PAGE = 12'hFFF;

  localparam logic [15:0] A_KDATA = 16'hFFF0;
  localparam logic [15:0] A_SDATA = 16'hFFF2;
  localparam logic [15:0] A_KCTRL = 16'hFFF4;
  localparam logic [15:0] A_SCTRL = 16'hFFF6;
  localparam logic [15:0] A_HEX   = 16'hFFF8;
  localparam logic [15:0] A_LEDR  = 16'hFFFA;
  localparam logic [15:0] A_LEDG  = 16'hFFFC;

  localparam int CTRL_RDY = 0;
  localparam int CTRL_OVR = 2;

  localparam logic [15:0] RD_DEAD = 16'hDEAD;

  typedef enum logic [2:0] {
    REG_KDATA,
    REG_SDATA,
    REG_KCTRL,
    REG_SCTRL,
    REG_HEX,
    REG_LEDR,
    REG_LEDG,
    REG_NONE
  } io_reg_e;

  // Exact byte-address match; odd addresses and 0xFFFE fall to REG_NONE.
  function automatic io_reg_e decode_reg(input logic [15:0] addr);
    case (addr)
      A_KDATA: return REG_KDATA;
      A_SDATA: return REG_SDATA;
      A_KCTRL: return REG_KCTRL;
      A_SCTRL: return REG_SCTRL;
      A_HEX:   return REG_HEX;
      A_LEDR:  return REG_LEDR;
      A_LEDG:  return REG_LEDG;
      default: return REG_NONE;
    endcase
  endfunction

  function automatic logic [15:0] ctrl_word(input logic rdy, input logic ovr);
    logic [15:0] w;
    w = '0;
    w[CTRL_RDY] = rdy;
    w[CTRL_OVR] = ovr;
    return w;
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_io_debounce.sv
// Two-flop synchronizer plus per-bit debouncer. o_evt pulses in the cycle
// whose closing edge commits a debounced change (rising only when EVT_RISE).
module io_debounce #(
  parameter int WIDTH    = 4,
  parameter int DEBN     = 50000,
  parameter bit INVERT   = 1'b0,
  parameter bit EVT_RISE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_deb,
  output logic [WIDTH-1:0] o_evt
);

  localparam int CW = $clog2(DEBN + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBN);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBN - 1);
  localparam logic [WIDTH-1:0] INV_MASK = {WIDTH{INVERT}};

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_deb;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_take;

  assign w_sync = r_sync2 ^ INV_MASK;

  always_comb begin
    w_diff = '0;
    w_take = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_diff[i] = (w_sync[i] != r_deb[i]);
      w_take[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
    end
  end

  assign o_deb = r_deb;
  assign o_evt = EVT_RISE ? (w_take & w_sync) : w_take;

  // Synchronizers reset to the raw inactive level so no edge is seen at reset exit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= INV_MASK;
      r_sync2 <= INV_MASK;
      r_deb   <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (w_take[i]) begin
          r_deb[i] <= w_sync[i];
          r_cnt[i] <= '0;
        end else if (w_diff[i]) begin
          if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + 1'b1;
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO responder for the 0xFFF0-0xFFFE window: debounced key/switch reads with
// sticky RDY/OVR status, plus write/readback display registers.
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
#(
  parameter int DBITS = 16,
  parameter int DEBN  = 50000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DBITS-1:0] ADDR,
  input  logic [DBITS-1:0] DIN,
  input  logic             WE,
  input  logic             RE,
  output logic [DBITS-1:0] DOUT,
  output logic             SEL,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [15:0]      HEX,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG
);

  // Bus protocol: single-cycle strobes, no handshake. DOUT is combinational
  // from ADDR; WE and RE qualified by SEL take effect at the next CLK edge.
  logic [3:0]  w_key_deb, w_key_evt;
  logic [9:0]  w_sw_deb,  w_sw_evt;
  logic        w_sel, w_wr, w_rd;
  io_reg_e     w_reg;
  logic        w_key_ev, w_sw_ev;
  logic        w_kd_rd, w_sd_rd, w_kc_clr, w_sc_clr;
  logic [DBITS-1:0] w_dout;

  logic        r_krdy, r_kovr, r_srdy, r_sovr;
  logic [15:0] r_hex;
  logic [9:0]  r_ledr;
  logic [7:0]  r_ledg;

  io_debounce #(.WIDTH(4), .DEBN(DEBN), .INVERT(1'b1), .EVT_RISE(1'b1)) u_key_deb (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_raw (KEY),
    .o_deb (w_key_deb),
    .o_evt (w_key_evt)
  );

  io_debounce #(.WIDTH(10), .DEBN(DEBN), .INVERT(1'b0), .EVT_RISE(1'b0)) u_sw_deb (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_raw (SW),
    .o_deb (w_sw_deb),
    .o_evt (w_sw_evt)
  );

  assign w_sel    = (ADDR[15:4] == IO_PAGE);
  assign w_reg    = decode_reg(ADDR[15:0]);
  assign w_wr     = WE & w_sel;
  assign w_rd     = RE & w_sel;
  assign w_key_ev = |w_key_evt;
  assign w_sw_ev  = |w_sw_evt;
  assign w_kd_rd  = w_rd && (w_reg == REG_KDATA);
  assign w_sd_rd  = w_rd && (w_reg == REG_SDATA);
  assign w_kc_clr = w_wr && (w_reg == REG_KCTRL) && !DIN[CTRL_OVR];
  assign w_sc_clr = w_wr && (w_reg == REG_SCTRL) && !DIN[CTRL_OVR];

  // An event always wins over a same-cycle read clear (RDY) or write clear (OVR).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_krdy <= 1'b0;
      r_kovr <= 1'b0;
      r_srdy <= 1'b0;
      r_sovr <= 1'b0;
      r_hex  <= '0;
      r_ledr <= '0;
      r_ledg <= '0;
    end else begin
      if (w_key_ev)     r_krdy <= 1'b1;
      else if (w_kd_rd) r_krdy <= 1'b0;
      if (w_key_ev && r_krdy && !w_kd_rd) r_kovr <= 1'b1;
      else if (w_kc_clr)                  r_kovr <= 1'b0;

      if (w_sw_ev)      r_srdy <= 1'b1;
      else if (w_sd_rd) r_srdy <= 1'b0;
      if (w_sw_ev && r_srdy && !w_sd_rd) r_sovr <= 1'b1;
      else if (w_sc_clr)                 r_sovr <= 1'b0;

      if (w_wr && (w_reg == REG_HEX))  r_hex  <= DIN[15:0];
      if (w_wr && (w_reg == REG_LEDR)) r_ledr <= DIN[9:0];
      if (w_wr && (w_reg == REG_LEDG)) r_ledg <= DIN[7:0];
    end
  end

  always_comb begin
    w_dout = '0;
    if (w_sel) begin
      case (w_reg)
        REG_KDATA: w_dout = {12'b0, w_key_deb};
        REG_SDATA: w_dout = {6'b0, w_sw_deb};
        REG_KCTRL: w_dout = ctrl_word(r_krdy, r_kovr);
        REG_SCTRL: w_dout = ctrl_word(r_srdy, r_sovr);
        REG_HEX:   w_dout = r_hex;
        REG_LEDR:  w_dout = {6'b0, r_ledr};
        REG_LEDG:  w_dout = {8'b0, r_ledg};
        default:   w_dout = RD_DEAD;
      endcase
    end
  end

  assign DOUT = w_dout;
  assign SEL  = w_sel;
  assign HEX  = r_hex;
  assign LEDR = r_ledr;
  assign LEDG = r_ledg;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl with DEBN=4: drivers push expected values,
// a negedge monitor pops and compares against the selected DUT output.
module tb_mmio_io_ctrl;

  localparam int W = 16;
  localparam int K_DOUT = 0, K_HEX = 1, K_LEDR = 2, K_LEDG = 3, K_SEL = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [W-1:0]  ADDR, DIN, DOUT;
  logic          WE, RE, SEL;
  logic [3:0]    KEY;
  logic [9:0]    SW;
  logic [15:0]   HEX;
  logic [9:0]    LEDR;
  logic [7:0]    LEDG;

  logic [W-1:0]  exp_q[$];
  int            kind_q[$];
  string         name_q[$];
  logic          chk_req = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  mmio_io_ctrl #(.DBITS(16), .DEBN(4)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN), .WE(WE), .RE(RE),
    .DOUT(DOUT), .SEL(SEL), .KEY(KEY), .SW(SW), .HEX(HEX), .LEDR(LEDR), .LEDG(LEDG)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // drivers: inputs change 1 time unit after the rising edge
  task automatic chk(input int kind, input logic [15:0] addr, input logic re,
                     input logic [15:0] exp, input string nm);
    ADDR = addr;
    RE   = re;
    exp_q.push_back(exp);
    kind_q.push_back(kind);
    name_q.push_back(nm);
    chk_req = 1'b1;
    tick();
    RE      = 1'b0;
    chk_req = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    ADDR = addr;
    DIN  = data;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    logic [W-1:0] e, act;
    int k;
    string nm;
    if (chk_req) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: monitor saw a check with no expected entry");
      end else begin
        e  = exp_q.pop_front();
        k  = kind_q.pop_front();
        nm = name_q.pop_front();
        case (k)
          K_HEX:   act = HEX;
          K_LEDR:  act = {6'b0, LEDR};
          K_LEDG:  act = {8'b0, LEDG};
          K_SEL:   act = {15'b0, SEL};
          default: act = DOUT;
        endcase
        if (act !== e) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    ADDR = '0; DIN = '0; WE = 1'b0; RE = 1'b0;
    KEY = 4'hF; SW = '0;
    repeat (3) tick();
    RESET = 1'b0;

    // reset state
    chk(K_HEX,  16'h0000, 1'b0, 16'h0000, "rst_hex");
    chk(K_LEDR, 16'h0000, 1'b0, 16'h0000, "rst_ledr");
    chk(K_LEDG, 16'h0000, 1'b0, 16'h0000, "rst_ledg");
    chk(K_DOUT, 16'hFFF0, 1'b0, 16'h0000, "rst_kdata");
    chk(K_DOUT, 16'hFFF2, 1'b0, 16'h0000, "rst_sdata");
    chk(K_DOUT, 16'hFFF4, 1'b0, 16'h0000, "rst_kctrl");
    chk(K_DOUT, 16'hFFF6, 1'b0, 16'h0000, "rst_sctrl");

    // display writes and readback
    wr(16'hFFF8, 16'h1234);
    chk(K_HEX,  16'h0000, 1'b0, 16'h1234, "hex_wr");
    wr(16'hFFFA, 16'hFFFF);
    chk(K_LEDR, 16'h0000, 1'b0, 16'h03FF, "ledr_wr");
    wr(16'hFFFC, 16'h01A5);
    chk(K_LEDG, 16'h0000, 1'b0, 16'h00A5, "ledg_wr");
    chk(K_DOUT, 16'hFFF8, 1'b0, 16'h1234, "hex_rd");
    chk(K_DOUT, 16'hFFFA, 1'b0, 16'h03FF, "ledr_rd");
    chk(K_DOUT, 16'hFFFC, 1'b0, 16'h00A5, "ledg_rd");
    chk(K_DOUT, 16'hFFFE, 1'b0, 16'hDEAD, "dead_fffe");
    chk(K_DOUT, 16'hFFF1, 1'b0, 16'hDEAD, "dead_odd");
    chk(K_SEL,  16'hFFF0, 1'b0, 16'h0001, "sel_hi");
    chk(K_SEL,  16'h0FF8, 1'b0, 16'h0000, "sel_lo");
    wr(16'h0FF8, 16'hBEEF);
    chk(K_HEX,  16'h0000, 1'b0, 16'h1234, "sel_lo_wr_ignored");

    // key press qualifies exactly 6 edges after the raw change
    KEY = 4'b1101;
    repeat (5) tick();
    chk(K_DOUT, 16'hFFF0, 1'b0, 16'h0000, "key_before_qual");
    chk(K_DOUT, 16'hFFF0, 1'b0, 16'h0002, "key_qual");
    chk(K_DOUT, 16'hFFF4, 1'b0, 16'h0001, "krdy_set");
    chk(K_DOUT, 16'hFFF0, 1'b1, 16'h0002, "kdata_rd_clear");
    chk(K_DOUT, 16'hFFF4, 1'b0, 16'h0000, "krdy_cleared");
    KEY = 4'hF;
    repeat (8) tick();
    chk(K_DOUT, 16'hFFF0, 1'b0, 16'h0000, "key_release");
    chk(K_DOUT, 16'hFFF4, 1'b0, 16'h0000, "release_no_event");

    // glitch of 3 cycles rejected
    KEY = 4'b1011;
    repeat (3) tick();
    KEY = 4'hF;
    repeat (8) tick();
    chk(K_DOUT, 16'hFFF0, 1'b0, 16'h0000, "glitch_kdata");
    chk(K_DOUT, 16'hFFF4, 1'b0, 16'h0000, "glitch_kctrl");

    // switch overrun
    SW = 10'h001;
    repeat (10) tick();
    chk(K_DOUT, 16'hFFF6, 1'b0, 16'h0001, "srdy_set");
    SW = 10'h003;
    repeat (10) tick();
    chk(K_DOUT, 16'hFFF6, 1'b0, 16'h0005, "sovr_set");
    wr(16'hFFF6, 16'h0000);
    chk(K_DOUT, 16'hFFF6, 1'b0, 16'h0001, "sovr_clear");
    chk(K_DOUT, 16'hFFF2, 1'b1, 16'h0003, "sdata_rd");
    chk(K_DOUT, 16'hFFF6, 1'b0, 16'h0000, "srdy_cleared");

    // event coinciding with a KDATA read while KRDY=1
    KEY = 4'b1110;
    repeat (8) tick();
    chk(K_DOUT, 16'hFFF4, 1'b0, 16'h0001, "krdy_pre");
    KEY = 4'b0110;
    repeat (5) tick();
    chk(K_DOUT, 16'hFFF0, 1'b1, 16'h0001, "rd_with_event");
    chk(K_DOUT, 16'hFFF4, 1'b0, 16'h0001, "ev_rd_no_ovr");
    chk(K_DOUT, 16'hFFF0, 1'b0, 16'h0009, "two_keys");

    // event setting OVR coinciding with a CTRL write clearing it
    KEY = 4'b0111;
    repeat (8) tick();
    KEY = 4'b0110;
    repeat (5) tick();
    wr(16'hFFF4, 16'h0000);
    chk(K_DOUT, 16'hFFF4, 1'b0, 16'h0005, "ovr_beats_clear");
    wr(16'hFFF4, 16'h0000);
    chk(K_DOUT, 16'hFFF4, 1'b0, 16'h0001, "kovr_clear");
    chk(K_DOUT, 16'hFFF0, 1'b1, 16'h0009, "kdata_rd2");
    chk(K_DOUT, 16'hFFF4, 1'b0, 16'h0000, "krdy_cleared2");

    // reset two counts into SW[9] qualification
    KEY = 4'hF;
    SW  = 10'h200;
    repeat (4) tick();
    RESET = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;
    chk(K_HEX,  16'h0000, 1'b0, 16'h0000, "rst2_hex");
    chk(K_LEDR, 16'h0000, 1'b0, 16'h0000, "rst2_ledr");
    chk(K_LEDG, 16'h0000, 1'b0, 16'h0000, "rst2_ledg");
    chk(K_DOUT, 16'hFFF4, 1'b0, 16'h0000, "rst2_kctrl");
    chk(K_DOUT, 16'hFFF6, 1'b0, 16'h0000, "rst2_sctrl");
    chk(K_DOUT, 16'hFFF2, 1'b0, 16'h0000, "sw9_before_qual");
    chk(K_DOUT, 16'hFFF2, 1'b0, 16'h0200, "sw9_qual");
    chk(K_DOUT, 16'hFFF6, 1'b0, 16'h0001, "sw9_srdy");

    repeat (2) tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
